// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder: access-size codes,
// FSM state encoding and the byte-lane write mask.
package dmem_pkg;

    localparam logic [1:0] FMT_WORD = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_BYTE = 2'b10;
    localparam logic [1:0] FMT_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    function automatic logic [3:0] byte_mask(input logic [1:0] fmt, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (fmt)
            FMT_WORD: mask = 4'b1111;
            FMT_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            FMT_BYTE: mask = 4'b0001 << lane;
            FMT_RSVD: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store port between the multicycle CPU (master) and the data memory (slave).
interface dmem_resp_if;
    logic        dmem_r;
    logic        dmem_w;
    logic [1:0]  store_format_signal;
    logic [31:0] data_addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        ready;
    logic        err;

    modport master (
        output dmem_r, dmem_w, store_format_signal, data_addr, w_data,
        input  r_data, ready, err
    );

    modport slave (
        input  dmem_r, dmem_w, store_format_signal, data_addr, w_data,
        output r_data, ready, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-data replication and byte mask on the way in,
// right-justified zero-filled load data on the way out.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [1:0]  lane,
    input  logic [31:0] w_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] rd_aligned,
    output logic        misalign
);
    logic [31:0] shifted;

    assign be      = byte_mask(fmt, lane);
    assign shifted = rd_word >> {lane, 3'b000};

    // The reserved size code is folded in here so the top sees one format fault.
    assign misalign = (fmt == FMT_RSVD) ||
                      ((fmt == FMT_HALF) && lane[0]) ||
                      ((fmt == FMT_WORD) && (lane != 2'b00));

    always_comb begin
        wr_word    = w_data;
        rd_aligned = 32'h0;
        case (fmt)
            FMT_WORD: begin
                wr_word    = w_data;
                rd_aligned = shifted;
            end
            FMT_HALF: begin
                wr_word    = {2{w_data[15:0]}};
                rd_aligned = {16'h0, shifted[15:0]};
            end
            FMT_BYTE: begin
                wr_word    = {4{w_data[7:0]}};
                rd_aligned = {24'h0, shifted[7:0]};
            end
            FMT_RSVD: begin
                wr_word    = w_data;
                rd_aligned = 32'h0;
            end
        endcase
    end
endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised storage, programmable read latency,
// one-cycle ready pulse per request with err flagging rejected accesses.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic        clk,
    input logic        rst,
    dmem_resp_if.slave bus
);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(READ_LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      r_data_q, r_data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       fmt_q, fmt_d;

    logic [31:0] word_off;
    logic        in_range, idle, req, bad, wr_en;
    logic [1:0]  al_fmt, al_lane;
    logic [3:0]  be;
    logic [31:0] wr_word, rd_aligned;
    logic        misalign;

    assign word_off = (bus.data_addr - ADDR_BASE) >> 2;
    assign in_range = (bus.data_addr >= ADDR_BASE) && (word_off < 32'(DEPTH_WORDS));
    assign idle     = (state_q == ST_IDLE);
    assign req      = bus.dmem_r | bus.dmem_w;

    // Live request fields steer the aligner at accept; latched ones while a read is in flight.
    assign al_fmt  = idle ? bus.store_format_signal : fmt_q;
    assign al_lane = idle ? bus.data_addr[1:0] : lane_q;

    dmem_lane_align u_align (
        .fmt        (al_fmt),
        .lane       (al_lane),
        .w_data     (bus.w_data),
        .rd_word    (mem[idx_q]),
        .be         (be),
        .wr_word    (wr_word),
        .rd_aligned (rd_aligned),
        .misalign   (misalign)
    );

    assign bad   = !in_range || misalign || (bus.dmem_r && bus.dmem_w);
    assign wr_en = idle && bus.dmem_w && !bad && !rst;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_off[IDX_W-1:0]][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        r_data_d = r_data_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        fmt_d    = fmt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d  = word_off[IDX_W-1:0];
                    lane_d = bus.data_addr[1:0];
                    fmt_d  = bus.store_format_signal;
                    if (bad) begin
                        state_d  = ST_RESP;
                        err_d    = 1'b1;
                        r_data_d = 32'h0;
                    end else if (bus.dmem_w) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    r_data_d = rd_aligned;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            r_data_q <= 32'h0;
            idx_q    <= '0;
            lane_q   <= 2'b00;
            fmt_q    <= FMT_WORD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            r_data_q <= r_data_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            fmt_q    <= fmt_d;
        end
    end

    assign bus.r_data = r_data_q;
    assign bus.ready  = (state_q == ST_RESP);
    assign bus.err    = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: three instances (latency 1, 2, 15) share one stimulus;
// the latency-2 instance is checked transaction by transaction.
module tb_dmem_resp;
    import dmem_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmem_r = 1'b0;
    logic        dmem_w = 1'b0;
    logic [1:0]  fmt = FMT_WORD;
    logic [31:0] addr = 32'h1001_0000;
    logic [31:0] wdata = 32'h0;

    always #5 clk = ~clk;

    dmem_resp_if bus_l1 ();
    dmem_resp_if bus_l2 ();
    dmem_resp_if bus_l15 ();

    assign bus_l1.dmem_r               = dmem_r;
    assign bus_l1.dmem_w               = dmem_w;
    assign bus_l1.store_format_signal  = fmt;
    assign bus_l1.data_addr            = addr;
    assign bus_l1.w_data               = wdata;
    assign bus_l2.dmem_r               = dmem_r;
    assign bus_l2.dmem_w               = dmem_w;
    assign bus_l2.store_format_signal  = fmt;
    assign bus_l2.data_addr            = addr;
    assign bus_l2.w_data               = wdata;
    assign bus_l15.dmem_r              = dmem_r;
    assign bus_l15.dmem_w              = dmem_w;
    assign bus_l15.store_format_signal = fmt;
    assign bus_l15.data_addr           = addr;
    assign bus_l15.w_data              = wdata;

    dmem_resp #(.READ_LATENCY(1)) u_dut_l1 (.clk(clk), .rst(rst), .bus(bus_l1));
    dmem_resp #(.READ_LATENCY(LAT)) u_dut (.clk(clk), .rst(rst), .bus(bus_l2));
    dmem_resp #(.READ_LATENCY(15)) u_dut_l15 (.clk(clk), .rst(rst), .bus(bus_l15));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    bit          sb_on = 1'b1;
    logic [31:0] last_rd = 32'h0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb_on && bus_l2.ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", {31'h0, bus_l2.ready}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("ready_cycle", cyc, e.cyc);
                check("err", {31'h0, bus_l2.err}, {31'h0, e.err});
                check("r_data", bus_l2.r_data, e.rdata);
            end
        end
    end

    // Drives one request held until ready, dropped in the following cycle.
    task automatic req(input logic r, input logic w, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] rd_exp);
        exp_t x;
        x.cyc   = cyc + 1 + ((r && !w && !e) ? LAT : 0);
        x.err   = e;
        x.rdata = rd_exp;
        sb_q.push_back(x);
        dmem_r = r;
        dmem_w = w;
        fmt    = f;
        addr   = a;
        wdata  = d;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            check("ready_timeout", sb_q.size(), 32'h0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        dmem_r = 1'b0;
        dmem_w = 1'b0;
    endtask

    task automatic wr(input logic [1:0] f, input logic [31:0] a, input logic [31:0] d);
        req(1'b0, 1'b1, f, a, d, 1'b0, last_rd);
    endtask

    task automatic rd(input logic [1:0] f, input logic [31:0] a, input logic [31:0] exp);
        last_rd = exp;
        req(1'b1, 1'b0, f, a, 32'h0, 1'b0, exp);
    endtask

    task automatic bad(input logic r, input logic w, input logic [1:0] f, input logic [31:0] a);
        last_rd = 32'h0;
        req(r, w, f, a, 32'hFFFF_FFFF, 1'b1, 32'h0);
    endtask

    bit          armed = 1'b0;
    int unsigned rdy_cyc[3];
    logic [31:0] rdy_data[3];
    logic        rdy_err[3];

    always @(negedge clk) begin
        if (armed) begin
            if (bus_l1.ready && rdy_cyc[0] == 0) begin
                rdy_cyc[0] = cyc; rdy_data[0] = bus_l1.r_data; rdy_err[0] = bus_l1.err;
            end
            if (bus_l2.ready && rdy_cyc[1] == 0) begin
                rdy_cyc[1] = cyc; rdy_data[1] = bus_l2.r_data; rdy_err[1] = bus_l2.err;
            end
            if (bus_l15.ready && rdy_cyc[2] == 0) begin
                rdy_cyc[2] = cyc; rdy_data[2] = bus_l15.r_data; rdy_err[2] = bus_l15.err;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned e_acc;
        rdy_cyc = '{0, 0, 0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'h0, bus_l2.ready}, 32'h0);
        check("reset_err", {31'h0, bus_l2.err}, 32'h0);
        check("reset_r_data", bus_l2.r_data, 32'h0);
        check("reset_ready_l15", {31'h0, bus_l15.ready}, 32'h0);
        rst = 1'b0;

        wr(FMT_WORD, 32'h1001_0004, 32'hDEAD_BEEF);
        rd(FMT_WORD, 32'h1001_0004, 32'hDEAD_BEEF);

        wr(FMT_BYTE, 32'h1001_0007, 32'h0000_005A);
        rd(FMT_BYTE, 32'h1001_0007, 32'h0000_005A);
        rd(FMT_HALF, 32'h1001_0006, 32'h0000_5AAD);
        rd(FMT_WORD, 32'h1001_0004, 32'h5AAD_BEEF);

        bad(1'b0, 1'b1, FMT_HALF, 32'h1001_0005);
        rd(FMT_WORD, 32'h1001_0004, 32'h5AAD_BEEF);
        bad(1'b1, 1'b0, FMT_WORD, 32'h1001_0002);
        bad(1'b1, 1'b0, FMT_RSVD, 32'h1001_0004);
        bad(1'b1, 1'b0, FMT_WORD, 32'h1000_FFFC);
        wr(FMT_WORD, 32'h1001_0FFC, 32'h0BAD_F00D);
        rd(FMT_WORD, 32'h1001_0FFC, 32'h0BAD_F00D);
        bad(1'b1, 1'b0, FMT_WORD, 32'h1001_1000);

        wr(FMT_WORD, 32'h1001_0000, 32'hCAFE_F00D);
        bad(1'b1, 1'b1, FMT_WORD, 32'h1001_0000);
        rd(FMT_WORD, 32'h1001_0000, 32'hCAFE_F00D);
        wr(FMT_HALF, 32'h1001_0002, 32'h1234_ABCD);
        rd(FMT_WORD, 32'h1001_0000, 32'hABCD_F00D);
        // Back-to-back identical calls keep the strobe high straight through RESP.
        wr(FMT_BYTE, 32'h1001_0001, 32'h0000_0077);
        wr(FMT_BYTE, 32'h1001_0001, 32'h0000_0077);
        rd(FMT_WORD, 32'h1001_0000, 32'hABCD_770D);
        rd(FMT_HALF, 32'h1001_0000, 32'h0000_770D);
        rd(FMT_BYTE, 32'h1001_0003, 32'h0000_00AB);

        sb_on  = 1'b0;
        dmem_r = 1'b1;
        fmt    = FMT_WORD;
        addr   = 32'h1001_0004;
        @(posedge clk);
        #1;
        check("busy_no_ready", {31'h0, bus_l2.ready}, 32'h0);
        rst    = 1'b1;
        dmem_r = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_ready", {31'h0, bus_l2.ready}, 32'h0);
        end
        check("rst_r_data", bus_l2.r_data, 32'h0);
        @(posedge clk);
        #1;
        sb_on   = 1'b1;
        last_rd = 32'h0;
        rd(FMT_WORD, 32'h1001_0004, 32'h5AAD_BEEF);

        sb_on = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        dmem_w = 1'b1;
        fmt    = FMT_WORD;
        addr   = 32'h1001_0010;
        wdata  = 32'h600D_CAFE;
        @(posedge clk);
        #1;
        dmem_w = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        e_acc  = cyc + 1;
        armed  = 1'b1;
        dmem_r = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            dmem_r = 1'($urandom_range(0, 1));
            dmem_w = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            @(posedge clk);
            #1;
        end
        dmem_r = 1'b0;
        dmem_w = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        armed = 1'b0;
        check("l1_ready_cycle", rdy_cyc[0], e_acc + 1);
        check("l2_ready_cycle", rdy_cyc[1], e_acc + 2);
        check("l15_ready_cycle", rdy_cyc[2], e_acc + 15);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sweep_err_%0d", k), {31'h0, rdy_err[k]}, 32'h0);
            check($sformatf("sweep_r_data_%0d", k), rdy_data[k], 32'h600D_CAFE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
